// File: rtl/tbus_mem_responder_pkg.sv
// tbus_mem_responder_pkg: shared tbus defines, optype codes and responder state encoding
`ifndef TBUS_MEM_RESPONDER_DEFS
`define TBUS_MEM_RESPONDER_DEFS
`define TBUS_OPTYPE_RANGE 1:0
`define RESULT_RANGE 63:0
`define SRC_RANGE 63:0
`define TBUS_READ 2'd0
`define TBUS_WRITE 2'd1
`endif
package tbus_mem_responder_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10} resp_state_e;
  localparam logic [`TBUS_OPTYPE_RANGE] TBUS_OP_READ = `TBUS_READ;
  localparam logic [`TBUS_OPTYPE_RANGE] TBUS_OP_WRITE = `TBUS_WRITE;
endpackage

// File: rtl/tbus_resp_ram.sv
// tbus_resp_ram: single-port 64-bit masked-write array with combinational read
module tbus_resp_ram #(
  parameter int DEPTH = 4096,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  input  logic [63:0]   wmask,
  output logic [63:0]   rdata
);
  logic [63:0] mem [DEPTH];
  assign rdata = mem[addr];
  // merge masked write bits into the addressed word
  always_ff @(posedge clock)
    if (we) mem[addr] <= (mem[addr] & ~wmask) | (wdata & wmask);
endmodule

// File: rtl/tbus_mem_responder.sv
// tbus_mem_responder: tbus responder with fixed-latency memory; TBUS_MEM_RESPONDER_FAULT_EN adds tbus_access_fault
module tbus_mem_responder
  import tbus_mem_responder_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int LATENCY = 2,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic                      clock,
  input  logic                      reset_n,
`ifdef TBUS_MEM_RESPONDER_FAULT_EN
  output logic                      tbus_access_fault,
`endif
  input  logic                      tbus_index_valid,
  output logic                      tbus_index_ready,
  input  logic [`RESULT_RANGE]      tbus_index,
  input  logic [`SRC_RANGE]         tbus_write_data,
  input  logic [63:0]               tbus_write_mask,
  input  logic [`TBUS_OPTYPE_RANGE] tbus_operation_type,
  output logic [`RESULT_RANGE]      tbus_read_data,
  output logic                      tbus_operation_done,
  input  logic                      flush
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  resp_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0] data_q, data_d, ram_rdata, rd_word;
  logic [AW-1:0] word_idx;
  logic fire, is_write, oob, we;
  assign word_idx = AW'((tbus_index - BASE_ADDR) >> 3);
  assign is_write = tbus_operation_type == TBUS_OP_WRITE;
  assign tbus_index_ready = state_q == IDLE && !flush;
  assign fire = tbus_index_valid && tbus_index_ready;
  assign tbus_operation_done = state_q == DONE && !flush;
  assign tbus_read_data = tbus_operation_done ? data_q : '0;
`ifdef TBUS_MEM_RESPONDER_FAULT_EN
  logic fault_q, fault_d;
  assign oob = tbus_index < BASE_ADDR || (tbus_index - BASE_ADDR) >= 64'(DEPTH) * 64'd8;
  assign tbus_access_fault = tbus_operation_done && fault_q;
  // remember whether the accepted request was out of range
  always_comb fault_d = fire ? oob : fault_q;
  // fault flag register
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) fault_q <= 1'b0;
    else fault_q <= fault_d;
`else
  assign oob = 1'b0;
`endif
  assign we = fire && is_write && !oob;
  assign rd_word = oob ? '0 : ram_rdata;
  tbus_resp_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clock (clock),
    .we    (we),
    .addr  (word_idx),
    .wdata (tbus_write_data),
    .wmask (tbus_write_mask),
    .rdata (ram_rdata)
  );
  // next state: accept in IDLE, count down in BUSY so done lands LATENCY cycles after fire
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    data_d = data_q;
    if (flush && state_q != IDLE) state_d = IDLE;
    else if (state_q == IDLE) begin
      if (fire) begin
        state_d = LATENCY == 1 ? DONE : BUSY;
        cnt_d = CW'(LATENCY - 1);
        data_d = is_write ? '0 : rd_word;
      end
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q - CW'(1);
      state_d = cnt_q == CW'(1) ? DONE : BUSY;
    end else state_d = IDLE;
  end
  // state, counter and response data registers
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
    end
endmodule

// File: tb/tb_tbus_mem_responder.sv
// tb_tbus_mem_responder: directed plus random checks of tbus_mem_responder against a word-array reference model
module tb_tbus_mem_responder;
  import tbus_mem_responder_pkg::*;
  localparam int DEPTH = 16;
  localparam int LAT = 3;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [1:0] RD = TBUS_OP_READ;
  localparam logic [1:0] WR = TBUS_OP_WRITE;
  logic clock = 0, reset_n = 1, valid = 0, flush = 0;
  logic [63:0] index = BASE, wdata = 0, wmask = 0;
  logic [1:0] op = 0;
  logic ready, done;
  logic [63:0] rdata;
`ifdef TBUS_MEM_RESPONDER_FAULT_EN
  logic fault;
`endif
  int total = 0, bad = 0, w;
  logic [63:0] mm [DEPTH];
  logic [63:0] exp_data;
  logic exp_fault;
  always #5 clock = ~clock;
  tbus_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
    .clock               (clock),
    .reset_n             (reset_n),
`ifdef TBUS_MEM_RESPONDER_FAULT_EN
    .tbus_access_fault   (fault),
`endif
    .tbus_index_valid    (valid),
    .tbus_index_ready    (ready),
    .tbus_index          (index),
    .tbus_write_data     (wdata),
    .tbus_write_mask     (wmask),
    .tbus_operation_type (op),
    .tbus_read_data      (rdata),
    .tbus_operation_done (done),
    .flush               (flush)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask
  task automatic model_fire();
    logic [63:0] off = index - BASE;
    int idx = int'((off >> 3) % 64'(DEPTH));
    logic oob = 1'b0;
`ifdef TBUS_MEM_RESPONDER_FAULT_EN
    oob = index < BASE || off >= 64'(DEPTH * 8);
`endif
    exp_fault = oob;
    if (op == WR) begin
      if (!oob) mm[idx] = (mm[idx] & ~wmask) | (wdata & wmask);
      exp_data = 0;
    end else exp_data = oob ? 64'd0 : mm[idx];
  endtask
  task automatic fire_wait(output int waited);
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (!ready && waited < 20);
    chk("fire_ready", 64'(ready), 1);
    model_fire();
    @(posedge clock);
    #1;
  endtask
  task automatic check_resp();
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clock);
      chk("busy_ready", 64'(ready), 0);
      chk("done", 64'(done), 64'(k == LAT));
      chk("rdata", rdata, k == LAT ? exp_data : 64'd0);
`ifdef TBUS_MEM_RESPONDER_FAULT_EN
      chk("fault", 64'(fault), 64'(k == LAT && exp_fault));
`endif
    end
  endtask
  task automatic req(input logic [63:0] a, input logic [63:0] d, input logic [63:0] m, input logic [1:0] o);
    int ww;
    index = a;
    wdata = d;
    wmask = m;
    op = o;
    valid = 1;
    fire_wait(ww);
    valid = 0;
    check_resp();
  endtask
  initial begin
    #1 reset_n = 0;
    #1;
    chk("rst_ready", 64'(ready), 1);
    chk("rst_done", 64'(done), 0);
    chk("rst_rdata", rdata, 0);
    #10 reset_n = 1;
    for (int i = 0; i < DEPTH; i++) req(BASE + 64'(8 * i), 64'd0, '1, WR);
    req(BASE + 64'h10, 64'h1122334455667788, '1, WR);
    req(BASE + 64'h10, 64'd0, 64'd0, RD);
    req(BASE + 64'h20, 64'hAB << 24, 64'hFF << 24, WR);
    req(BASE + 64'h24, 64'd0, 64'd0, RD);
    index = BASE + 64'h10;
    op = RD;
    valid = 1;
    fire_wait(w);
    index = BASE + 64'h20;
    check_resp();
    fire_wait(w);
    chk("bp_refire_wait", 64'(w), 1);
    valid = 0;
    check_resp();
    @(negedge clock);
    chk("bp_no_extra_done", 64'(done), 0);
    @(posedge clock);
    #1;
    index = BASE + 64'h8;
    op = RD;
    valid = 1;
    fire_wait(w);
    valid = 0;
    flush = 1;
    @(negedge clock);
    chk("flush_busy_done", 64'(done), 0);
    @(posedge clock);
    #1 flush = 0;
    @(negedge clock);
    chk("flush_ready_c2", 64'(ready), 1);
    for (int k = 0; k < LAT; k++) begin
      @(negedge clock);
      chk("flush_no_done", 64'(done), 0);
    end
    req(BASE + 64'h10, 64'd0, 64'd0, RD);
    @(posedge clock);
    #1;
    index = BASE + 64'h20;
    op = RD;
    valid = 1;
    flush = 1;
    @(negedge clock);
    chk("flush_idle_ready", 64'(ready), 0);
    @(posedge clock);
    #1 flush = 0;
    fire_wait(w);
    chk("flush_idle_fire", 64'(w), 1);
    valid = 0;
    check_resp();
    @(posedge clock);
    #1;
    index = BASE + 64'h30;
    wdata = 64'h5555_AAAA_1234_5678;
    wmask = '1;
    op = WR;
    valid = 1;
    fire_wait(w);
    valid = 0;
    for (int k = 1; k < LAT; k++) begin
      @(negedge clock);
      chk("flush_done_pre", 64'(done), 0);
    end
    @(posedge clock);
    #1 flush = 1;
    @(negedge clock);
    chk("flush_done_done", 64'(done), 0);
    chk("flush_done_rdata", rdata, 0);
    @(posedge clock);
    #1 flush = 0;
    @(negedge clock);
    chk("flush_done_ready", 64'(ready), 1);
    req(BASE + 64'h30, 64'd0, 64'd0, RD);
    req(BASE + 64'h80, 64'hDEAD_BEEF_CAFE_F00D, '1, WR);
    req(BASE, 64'd0, 64'd0, RD);
    @(posedge clock);
    #1;
    index = BASE + 64'h8;
    op = RD;
    valid = 1;
    fire_wait(w);
    valid = 0;
    #2 reset_n = 0;
    #1;
    chk("arst_ready", 64'(ready), 1);
    chk("arst_done", 64'(done), 0);
    chk("arst_rdata", rdata, 0);
    @(posedge clock);
    #3 reset_n = 1;
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clock);
      chk("arst_no_done", 64'(done), 0);
    end
    for (int i = 0; i < 60; i++) begin
      logic [63:0] a, m;
      a = $urandom_range(0, 7) == 0 ? BASE - 64'($urandom_range(1, 64)) : BASE + 64'($urandom_range(0, 255));
      case ($urandom_range(0, 2))
        0: m = '1;
        1: m = 64'hFF << (8 * $urandom_range(0, 7));
        default: m = {$urandom, $urandom};
      endcase
      req(a, {$urandom, $urandom}, m, 2'($urandom_range(0, 3)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tbus_mem_responder.md
Name: tbus_mem_responder

Overview:
- Responder (slave) end of the trinity bus (tbus): accepts index/write-data/mask/optype requests from a tbus initiator (load/store unit or dcache refill path) and answers each with a single-cycle `tbus_operation_done` pulse plus read data.
- Backed by an internal word-addressed 64-bit memory array with a configurable, fixed response latency.
- Used as the memory model behind the memory block in simulation, and as a scratchpad responder in SoC builds.
- Single outstanding request; back-pressure via `tbus_index_ready`.

Parameters:
- DEPTH, 4096, number of 64-bit words in the backing array (power of two, >= 2).
- LATENCY, 2, cycles from request fire to the `tbus_operation_done` pulse (>= 1).
- BASE_ADDR, 64'h8000_0000, byte address mapped to word 0.

Ports:
- clock  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- tbus_index_valid  in  1  request valid from initiator.
- tbus_index_ready  out  1  responder can accept a request this cycle.
- tbus_index  in  `RESULT_RANGE  byte address.
- tbus_write_data  in  `SRC_RANGE  store data, already lane-aligned by initiator.
- tbus_write_mask  in  64  per-bit write enable.
- tbus_operation_type  in  `TBUS_OPTYPE_RANGE  `TBUS_READ or `TBUS_WRITE.
- tbus_read_data  out  `RESULT_RANGE  full aligned 64-bit word, valid only with done.
- tbus_operation_done  out  1  one-cycle completion pulse.
- flush  in  1  abort any in-flight request (driven by memblock2dcache_flush).

Behaviour:
- Reset (async, reset_n=0): state IDLE, latency counter 0, tbus_index_ready=1, tbus_operation_done=0, tbus_read_data=0. Array contents are not reset.
- States:
  - IDLE: ready=1. On fire (valid & ready) go to BUSY, load counter with LATENCY-1, and latch optype and read data.
  - BUSY: ready=0. Counter decrements each cycle. At counter==0 go to DONE.
  - DONE: done=1 and read_data driven for exactly this one cycle; ready=0; next state IDLE.
- Latency: done is asserted exactly LATENCY cycles after the fire cycle. With LATENCY=1, BUSY is skipped: IDLE -> DONE on fire.
- Word index = (tbus_index - BASE_ADDR) >> 3, truncated to log2(DEPTH) bits. Out-of-range addresses wrap modulo DEPTH. Low 3 address bits are ignored.
- Write: committed to the array in the fire cycle as mem = (mem & ~mask) | (wdata & mask). Read data is returned as 0 on the write's done pulse.
- Read: the array word is sampled in the fire cycle into a data register. A read following a write therefore sees the written value, because that write completed earlier.
- Any optype value other than `TBUS_READ/`TBUS_WRITE is treated as a read.
- tbus_read_data = 0 whenever done=0.
- Flush:
  - In BUSY or DONE: the next state is IDLE and done is forced 0 in the flush cycle; no done pulse is issued for the aborted request.
  - An aborted write remains committed; only the response is dropped.
  - In IDLE, flush blocks acceptance that cycle: ready is forced 0.
- Valid while not ready: the request is ignored; the initiator holds it until it fires.
- Reset asserted mid-BUSY: the request is dropped and no done pulse is issued after reset release.

Optional Feature:
- Macro: TBUS_MEM_RESPONDER_FAULT_EN.
- Defined: adds output `tbus_access_fault` (1 bit), asserted together with done when (tbus_index - BASE_ADDR) >= DEPTH*8 or tbus_index < BASE_ADDR. A faulting write does not modify the array. A faulting read returns 0. Reset value of the output is 0.
- Undefined: no fault port, and out-of-range addresses wrap.

Decomposition:
- Shared package/defines: `TBUS_READ, `TBUS_WRITE, `TBUS_OPTYPE_RANGE, `RESULT_RANGE, `SRC_RANGE; responder state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10).
- Sub-module: `tbus_resp_ram`, a single-port 64-bit masked-write array with combinational read, instantiated once. FSM, counter and flush logic stay in the top.

Test Plan:
- LATENCY=2: write addr 0x8000_0010, data 0x1122334455667788, mask all-ones, fired at cycle 0 -> done at cycle 2, ready low cycles 1–2; then a read of the same address -> done 2 cycles after its fire with read_data 0x1122334455667788.
- Masked byte store: write data 0xAB<<24 with mask 0xFF<<24 to a word holding 0 -> subsequent read returns 0x00000000AB000000.
- Back-pressure: valid held high continuously across two requests -> second fire occurs only in the IDLE cycle after done; exactly two done pulses; no request lost or duplicated.
- Flush at cycle 1 of a LATENCY=3 read -> no done pulse, ready=1 at cycle 2, and a new read fires and completes normally.
- Wrap: DEPTH=16, write to BASE_ADDR+0x80 -> read of BASE_ADDR+0x0 returns that data (macro undefined); with TBUS_MEM_RESPONDER_FAULT_EN defined -> tbus_access_fault=1 with done, and the read of BASE_ADDR+0x0 still returns the old value.
- Async reset asserted mid-BUSY -> ready=1 and done=0 immediately, and no done pulse appears after release.
